// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } uart_state_e;

   localparam int unsigned DIV_MIN       = 2;
   localparam int unsigned MAX_DATA_BITS = 9;

   // Narrower words are zero-extended, which leaves their parity unchanged.
   function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through transmit FIFO; rd_data always shows the oldest entry.
module uart_tx_fifo #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic                 pop,
   input  logic [DATA_BITS-1:0] wr_data,
   output logic [DATA_BITS-1:0] rd_data,
   output logic [CNT_W-1:0]     count,
   output logic                 full,
   output logic                 empty
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]     count_q;
   logic                 do_push, do_pop;

   assign full    = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_data = mem[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_engine.sv
// Buffered UART transmitter with runtime baud divisor, optional parity and 1/2 stop bits.
// All serial outputs are registered and change together, one cycle behind the FSM state.
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int unsigned DIV_W      = 16,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                 s00_axi_aclk,
   input  logic                 s00_axi_aresetn,
   input  logic [DIV_W-1:0]     div,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 two_stop,
   input  logic                 s_valid,
   input  logic [DATA_BITS-1:0] s_data,
   output logic                 s_ready,
   output logic                 uart_txd,
   output logic                 uart_clk_edge,
   output logic                 uart_clk,
   output logic                 tx_active,
   output logic                 tx_done,
   output logic [CNT_W-1:0]     fifo_count
);

   localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   uart_state_e          state_q;
   logic [DIV_W-1:0]     bcnt_q, divl_q, div_clamped;
   logic [BIT_W-1:0]     bit_idx_q;
   logic [DATA_BITS-1:0] data_q, fifo_rd_data;
   logic                 par_en_q, par_odd_q, two_stop_q, stop_idx_q;
   logic                 txd_q, clk_edge_q, uclk_q, active_q, done_q;
   logic                 fifo_full, fifo_empty, push, pop, last_cyc, tx_bit;

   assign push        = s_valid & ~fifo_full;
   assign pop         = (state_q == StIdle) & ~fifo_empty;
   assign s_ready     = ~fifo_full;
   assign div_clamped = (div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div;
   assign last_cyc    = (bcnt_q == divl_q - DIV_W'(1));

   uart_tx_fifo #(
      .DATA_BITS  (DATA_BITS),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) u_fifo (
      .clk     (s00_axi_aclk),
      .rst_n   (s00_axi_aresetn),
      .push    (push),
      .pop     (pop),
      .wr_data (s_data),
      .rd_data (fifo_rd_data),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      tx_bit = 1'b1;
      unique case (state_q)
         StStart:  tx_bit = 1'b0;
         StData:   tx_bit = data_q[bit_idx_q];
         StParity: tx_bit = parity_bit(MAX_DATA_BITS'(data_q), par_odd_q);
         default:  tx_bit = 1'b1;
      endcase
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         state_q    <= StIdle;
         bcnt_q     <= '0;
         divl_q     <= DIV_W'(DIV_MIN);
         bit_idx_q  <= '0;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         two_stop_q <= 1'b0;
         stop_idx_q <= 1'b0;
         txd_q      <= 1'b1;
         clk_edge_q <= 1'b0;
         uclk_q     <= 1'b0;
         active_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         txd_q      <= 1'b1;
         clk_edge_q <= 1'b0;
         uclk_q     <= 1'b0;
         active_q   <= 1'b0;
         done_q     <= 1'b0;
         if (state_q == StIdle) begin
            // Frame settings are frozen here for the whole frame.
            if (!fifo_empty) begin
               state_q    <= StStart;
               bcnt_q     <= '0;
               divl_q     <= div_clamped;
               data_q     <= fifo_rd_data;
               par_en_q   <= parity_en;
               par_odd_q  <= parity_odd;
               two_stop_q <= two_stop;
            end
         end else begin
            txd_q      <= tx_bit;
            active_q   <= 1'b1;
            clk_edge_q <= last_cyc;
            uclk_q     <= (bcnt_q < (divl_q >> 1));
            bcnt_q     <= last_cyc ? '0 : bcnt_q + DIV_W'(1);
            if (last_cyc) begin
               case (state_q)
                  StStart: begin
                     state_q   <= StData;
                     bit_idx_q <= '0;
                  end
                  StData: begin
                     if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
                        state_q    <= par_en_q ? StParity : StStop;
                        stop_idx_q <= 1'b0;
                     end else begin
                        bit_idx_q <= bit_idx_q + BIT_W'(1);
                     end
                  end
                  StParity: state_q <= StStop;
                  default: begin
                     if (stop_idx_q == two_stop_q) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                     end else begin
                        stop_idx_q <= 1'b1;
                     end
                  end
               endcase
            end
         end
      end
   end

   assign uart_txd      = txd_q;
   assign uart_clk_edge = clk_edge_q;
   assign uart_clk      = uclk_q;
   assign tx_active     = active_q;
   assign tx_done       = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench: expected line waveform built per frame from word and frame settings.
module tb_uart_tx_engine;

   localparam int unsigned DIV_W      = 16;
   localparam int unsigned DATA_BITS  = 8;
   localparam int unsigned FIFO_DEPTH = 16;
   localparam int unsigned CNT_W      = 5;

   logic                 s00_axi_aclk = 1'b0;
   logic                 s00_axi_aresetn = 1'b0;
   logic [DIV_W-1:0]     div = 16'd4;
   logic                 parity_en = 1'b0;
   logic                 parity_odd = 1'b0;
   logic                 two_stop = 1'b0;
   logic                 s_valid = 1'b0;
   logic [DATA_BITS-1:0] s_data = '0;
   logic                 s_ready;
   logic                 uart_txd;
   logic                 uart_clk_edge;
   logic                 uart_clk;
   logic                 tx_active;
   logic                 tx_done;
   logic [CNT_W-1:0]     fifo_count;

   int         n_assert = 0;
   int         n_fail = 0;
   bit         saw_full = 1'b0;
   logic [7:0] exp_q[$];

   always #5 s00_axi_aclk = ~s00_axi_aclk;

   uart_tx_engine #(
      .DIV_W      (DIV_W),
      .DATA_BITS  (DATA_BITS),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) dut (
      .s00_axi_aclk    (s00_axi_aclk),
      .s00_axi_aresetn (s00_axi_aresetn),
      .div             (div),
      .parity_en       (parity_en),
      .parity_odd      (parity_odd),
      .two_stop        (two_stop),
      .s_valid         (s_valid),
      .s_data          (s_data),
      .s_ready         (s_ready),
      .uart_txd        (uart_txd),
      .uart_clk_edge   (uart_clk_edge),
      .uart_clk        (uart_clk),
      .tx_active       (tx_active),
      .tx_done         (tx_done),
      .fifo_count      (fifo_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic push(input logic [7:0] w);
      int guard;
      guard   = 0;
      s_data  = w;
      s_valid = 1'b1;
      while (!s_ready && guard < 2000) begin
         if (!saw_full) chk("full_count", fifo_count, FIFO_DEPTH);
         saw_full = 1'b1;
         @(negedge s00_axi_aclk);
         guard++;
      end
      chk("push_accept", guard < 2000, 1);
      exp_q.push_back(w);
      @(negedge s00_axi_aclk);
      s_valid = 1'b0;
   endtask

   // Waits for the start bit then checks every cycle of the frame.
   // gap = expected negedges from call to first low sample (-1 = don't care).
   task automatic check_frame(input int div_in, input bit pe, input bit po, input bit ts,
                              input int gap);
      int         divl, nbits, wait_n;
      logic [7:0] w;
      logic       bits[12];
      logic [4:0] exp_v, obs_v;
      divl   = (div_in < 2) ? 2 : div_in;
      wait_n = 0;
      do begin
         @(negedge s00_axi_aclk);
         wait_n++;
      end while (uart_txd !== 1'b0 && wait_n < 400);
      chk("frame_start", uart_txd, 0);
      if (uart_txd !== 1'b0) return;
      if (gap >= 0) chk("start_gap", wait_n, gap);
      chk("queue_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() == 0) return;
      w     = exp_q.pop_front();
      nbits = 0;
      bits[nbits++] = 1'b0;
      for (int i = 0; i < 8; i++) bits[nbits++] = w[i];
      if (pe) bits[nbits++] = (^w) ^ po;
      bits[nbits++] = 1'b1;
      if (ts) bits[nbits++] = 1'b1;
      for (int b = 0; b < nbits; b++) begin
         for (int c = 0; c < divl; c++) begin
            if (b != 0 || c != 0) @(negedge s00_axi_aclk);
            exp_v = {bits[b], c < divl / 2, c == divl - 1, 1'b1, (b == nbits - 1) && (c == divl - 1)};
            obs_v = {uart_txd, uart_clk, uart_clk_edge, tx_active, tx_done};
            chk("frame_cycle", obs_v, exp_v);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] w;
      int         d;
      bit         pe, po, ts;

      // Reset state
      repeat (3) @(negedge s00_axi_aclk);
      chk("reset_state", {uart_txd, uart_clk, uart_clk_edge, tx_active, tx_done, s_ready, fifo_count},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0});
      s00_axi_aresetn = 1'b1;
      repeat (2) @(negedge s00_axi_aclk);

      // 8N1 at div 4, latency from push to start bit
      div = 16'd4;
      push(8'h55);
      check_frame(4, 0, 0, 0, 2);

      // Parity odd/even with two stop bits
      div = 16'd3; parity_en = 1'b1; parity_odd = 1'b1; two_stop = 1'b1;
      push(8'hA5);
      check_frame(3, 1, 1, 1, 2);
      parity_odd = 1'b0;
      push(8'hA5);
      check_frame(3, 1, 0, 1, 2);

      // FIFO fill with back-to-back frames
      parity_en = 1'b0; two_stop = 1'b0; saw_full = 1'b0;
      fork
         for (int i = 0; i < 20; i++) push(8'($urandom));
         for (int i = 0; i < 20; i++) check_frame(3, 0, 0, 0, (i == 0) ? -1 : 2);
      join
      chk("ready_dropped", saw_full, 1);
      chk("drained", {fifo_count, s_ready}, {5'd0, 1'b1});

      // Divisor change mid-frame only affects the next frame
      div = 16'd4;
      push(8'h3C);
      push(8'hC3);
      fork
         begin
            check_frame(4, 0, 0, 0, -1);
            check_frame(8, 0, 0, 0, 2);
         end
         begin
            repeat (10) @(negedge s00_axi_aclk);
            div = 16'd8;
         end
      join

      // Divisor 0 and 1 clamp to 2
      div = 16'd0;
      push(8'h81);
      check_frame(0, 0, 0, 0, 2);
      div = 16'd1;
      push(8'h7E);
      check_frame(1, 0, 0, 0, 2);

      // Random frames
      for (int k = 0; k < 12; k++) begin
         d  = int'($urandom_range(6, 0));
         pe = 1'($urandom);
         po = 1'($urandom);
         ts = 1'($urandom);
         w  = 8'($urandom);
         div = DIV_W'(d); parity_en = pe; parity_odd = po; two_stop = ts;
         push(w);
         check_frame(d, pe, po, ts, 2);
      end

      // Reset during DATA with words queued
      div = 16'd4; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
      push(8'h00);
      for (int i = 0; i < 5; i++) push(8'($urandom));
      repeat (4) @(negedge s00_axi_aclk);
      chk("pre_reset", {uart_txd, tx_active, fifo_count}, {1'b0, 1'b1, 5'd5});
      #2 s00_axi_aresetn = 1'b0;
      #1 chk("reset_midframe", {uart_txd, uart_clk, tx_active, tx_done, s_ready, fifo_count},
             {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0});
      exp_q.delete();
      repeat (2) @(negedge s00_axi_aclk);
      s00_axi_aresetn = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge s00_axi_aclk);
         chk("post_reset_idle", {uart_txd, tx_active, fifo_count}, {1'b1, 1'b0, 5'd0});
      end
      push(8'h96);
      check_frame(4, 0, 0, 0, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Parametrised successor to the fixed uart_clk divider: a buffered UART transmitter with a runtime-programmable baud divisor and a selectable frame format. The block accepts words through a valid/ready interface into an internal FIFO and serialises them on uart_txd. It also emits the bit-rate tick and square wave that the AXI-lite slave exposes for debug.

Parameters:
DIV_W, 16, width of baud divisor input (clock cycles per bit)
DATA_BITS, 8, data bits per frame, legal 5..9
FIFO_DEPTH, 16, transmit FIFO entries, power of two, >=2
CNT_W, $clog2(FIFO_DEPTH+1), width of fifo_count

Ports:
s00_axi_aclk  in  1  single clock, rising edge
s00_axi_aresetn  in  1  asynchronous active-low reset
div  in  DIV_W  clocks per bit; values 0 and 1 are treated as 2
parity_en  in  1  1 = append a parity bit
parity_odd  in  1  1 = odd parity, 0 = even parity
two_stop  in  1  1 = two stop bits, 0 = one stop bit
s_valid  in  1  input word valid
s_data  in  DATA_BITS  input word
s_ready  out  1  FIFO not full
uart_txd  out  1  serial line, idle high
uart_clk_edge  out  1  one-cycle pulse at the last cycle of each bit period
uart_clk  out  1  bit-rate square wave, low when idle
tx_active  out  1  frame in progress
tx_done  out  1  one-cycle pulse at the end of the last stop bit
fifo_count  out  CNT_W  words currently buffered

Behaviour:
- Reset (async assert, synchronous release): uart_txd=1, uart_clk=0, uart_clk_edge=0, tx_active=0, tx_done=0, fifo_count=0, s_ready=1. FIFO is emptied and the FSM returns to IDLE. Assertion mid-frame forces uart_txd=1 immediately; the partial frame is lost.
- Push: a word is accepted when s_valid & s_ready on a clock edge. s_ready = (fifo_count != FIFO_DEPTH), combinational from registered state.
- Pop occurs in IDLE when FIFO is non-empty. Push and pop in the same cycle leave fifo_count unchanged.
- FIFO is first-word-fall-through. Pointers wrap modulo FIFO_DEPTH.
- Frame-start capture: on IDLE->START the block latches div (clamped to >=2), parity_en, parity_odd, two_stop and the popped word. Input changes during a frame have no effect until the next frame.
- Latency: word pushed at edge N into an empty FIFO with FSM in IDLE -> uart_txd=0 from edge N+2.
- Baud counter bcnt runs 0..divl-1 while not IDLE and restarts at 0 on each bit.
  - uart_clk_edge=1 when bcnt==divl-1.
  - uart_clk=1 while bcnt < divl/2 (floor); 0 in IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: uart_txd=1, tx_active=0. If FIFO non-empty -> START.
  - START: uart_txd=0 for divl cycles -> DATA.
  - DATA: LSB first, DATA_BITS bits, bit index counter -> PARITY if parity_en, else STOP.
  - PARITY: txd = ^data XOR parity_odd -> STOP.
  - STOP: txd=1 for 1 or 2 bit periods. At the final edge, tx_done=1 and the FSM goes to IDLE.
- Back-to-back: the IDLE cycle after tx_done pops the next word, so the inter-frame gap is exactly one extra high cycle.
- tx_active=1 in START..STOP inclusive.
- Frame length in cycles = divl*(1+DATA_BITS+parity_en+1+two_stop).

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP), DIV_MIN=2 constant, parity function.
- One sub-module uart_tx_fifo: synchronous FWFT FIFO with parameters DATA_BITS and FIFO_DEPTH, exposing count, full and empty.

Test Plan:
- div=4, 8N1, push 0x55 -> txd: 0 for 4 cycles; then 1,0,1,0,1,0,1,0 at 4 cycles each; then 1 for 4 cycles; tx_done at cycle 40 after txd falls; tx_active high 40 cycles; 10 uart_clk_edge pulses.
- div=3, parity_en=1, parity_odd=1, two_stop=1, push 0xA5 -> parity bit 1, two stop bits, frame 36 cycles. Repeat with parity_odd=0 -> parity bit 0.
- Hold s_valid with 20 words while txd is busy -> s_ready drops after fifo_count=16; all 20 bytes are sent in order; each frame start is exactly one idle cycle after the previous tx_done.
- Change div 4->8 mid-frame -> current frame stays at 4 cycles/bit; next frame at 8 cycles/bit.
- div=0 and div=1 -> bit period 2 cycles; uart_clk high 1 cycle per bit.
- Assert s00_axi_aresetn=0 during DATA with 5 words queued -> txd=1 immediately; fifo_count=0, tx_active=0; after release nothing is transmitted until a new push.
